// File: rtl/viterbi_pkg.sv
// viterbi_pkg: trellis constants and helpers shared by the K=3 rate-1/2 encoder and decoder
package viterbi_pkg;
  localparam logic [2:0] G1 = 3'b111;
  localparam logic [2:0] G0 = 3'b101;
  localparam int N_STATES = 4;
  localparam logic [1:0] S00 = 2'd0;
  typedef enum logic [1:0] {RUN, FIND, TB, DONE} fsm_t;
  function automatic logic [1:0] exp_sym(input logic [1:0] s, input logic u);
    return {^({u, s} & G1), ^({u, s} & G0)};
  endfunction
  function automatic logic [1:0] next_state(input logic [1:0] s, input logic u);
    return {u, s[1]};
  endfunction
  function automatic logic [1:0] popcnt2(input logic [1:0] x);
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction
endpackage

// File: rtl/viterbi_decoder_acs.sv
// viterbi_acs: saturating add-compare-select for one trellis state; ties favour the s0=0 predecessor
module viterbi_acs #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_pm0,
  input  logic [W-1:0] i_pm1,
  input  logic [1:0]   i_bm0,
  input  logic [1:0]   i_bm1,
  output logic [W-1:0] o_pm,
  output logic         o_sel
);
  logic [W:0]   w_s0, w_s1;
  logic [W-1:0] w_c0, w_c1;
  assign w_s0  = {1'b0, i_pm0} + (W+1)'(i_bm0);
  assign w_s1  = {1'b0, i_pm1} + (W+1)'(i_bm1);
  assign w_c0  = w_s0[W] ? '1 : w_s0[W-1:0];
  assign w_c1  = w_s1[W] ? '1 : w_s1[W-1:0];
  assign o_sel = w_c1 < w_c0;
  assign o_pm  = o_sel ? w_c1 : w_c0;
endmodule

// File: rtl/viterbi_decoder.sv
// viterbi_decoder: hard-decision 4-state Viterbi decoder, one frame of FRAME_LEN symbols,
// ACS per handshake, then min-metric search and traceback into a parallel output word.
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 6,
  parameter int METRIC_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_sym,
  output logic                 out_valid,
  output logic [FRAME_LEN-1:0] out_bits,
  output logic [METRIC_W-1:0]  out_metric
);
  localparam int CW = $clog2(FRAME_LEN);
  fsm_t                  r_state, w_next;
  logic [CW-1:0]         r_cnt, r_t;
  logic [METRIC_W-1:0]   r_pm [N_STATES];
  logic [METRIC_W-1:0]   w_pm [N_STATES];
  logic [N_STATES-1:0]   w_sel;
  logic [N_STATES-1:0]   r_surv [FRAME_LEN];
  logic [1:0]            r_cur, w_best;
  logic [METRIC_W-1:0]   w_best_pm;
  logic [FRAME_LEN-2:0]  r_bits;
  logic                  w_hs;
  assign in_ready  = r_state == RUN;
  assign out_valid = r_state == DONE;
  assign w_hs      = in_valid & in_ready;
  // state {u,a} is reached from {a,0} and {a,1} with input u
  for (genvar n = 0; n < N_STATES; n++) begin : g_acs
    localparam logic [1:0] P0 = 2'(2 * (n % 2));
    localparam logic [1:0] P1 = 2'(2 * (n % 2) + 1);
    localparam logic       U  = 1'(n / 2);
    logic [1:0] w_bm0, w_bm1;
    assign w_bm0 = popcnt2(in_sym ^ exp_sym(P0, U));
    assign w_bm1 = popcnt2(in_sym ^ exp_sym(P1, U));
    viterbi_acs #(.W(METRIC_W)) u_acs (
      .i_pm0(r_pm[P0]),
      .i_pm1(r_pm[P1]),
      .i_bm0(w_bm0),
      .i_bm1(w_bm1),
      .o_pm (w_pm[n]),
      .o_sel(w_sel[n])
    );
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:  w_next = (w_hs && r_cnt == CW'(FRAME_LEN - 1)) ? FIND : RUN;
      FIND: w_next = TB;
      TB:   w_next = (r_t == '0) ? DONE : TB;
      DONE: w_next = RUN;
      default: w_next = RUN;
    endcase
  end
  always_comb begin
    w_best    = '0;
    w_best_pm = r_pm[0];
    for (int i = 1; i < N_STATES; i++)
      if (r_pm[i] < w_best_pm) begin
        w_best    = 2'(i);
        w_best_pm = r_pm[i];
      end
  end
  always_ff @(posedge clk) begin
    if (!rst_n || r_state == DONE) begin
      for (int i = 0; i < N_STATES; i++) r_pm[i] <= (2'(i) == S00) ? '0 : '1;
      r_cnt <= '0;
    end else if (w_hs) begin
      r_pm  <= w_pm;
      r_cnt <= r_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FRAME_LEN; i++) r_surv[i] <= '0;
      r_cur      <= '0;
      r_t        <= '0;
      r_bits     <= '0;
      out_bits   <= '0;
      out_metric <= '0;
    end else begin
      if (w_hs) r_surv[r_cnt] <= w_sel;
      if (r_state == FIND) begin
        out_metric <= w_best_pm;
        r_cur      <= w_best;
        r_t        <= CW'(FRAME_LEN - 1);
      end
      // bits enter at the top and shift down so symbol 0 ends at the MSB
      if (r_state == TB) begin
        r_bits <= {r_cur[1], r_bits[FRAME_LEN-2:1]};
        r_cur  <= {r_cur[0], r_surv[r_t][r_cur]};
        r_t    <= r_t - 1'b1;
        if (r_t == '0) out_bits <= {r_cur[1], r_bits};
      end
    end
  end
endmodule

// File: tb/tb_viterbi_decoder.sv
// tb_viterbi_decoder: scoreboard bench; expected frames come from a reference encoder and directed constants
module tb_viterbi_decoder;
  localparam int FL = 6;
  localparam int MW = 5;
  logic          clk = 0;
  logic          rst_n = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [1:0]    in_sym = '0;
  logic          out_valid;
  logic [FL-1:0] out_bits;
  logic [MW-1:0] out_metric;
  int n_run = 0, n_fail = 0, cyc = 0, last_hs = 0, last_wait = 0, first_wait = 0;
  logic [FL+MW-1:0] sb [$];
  logic [2*FL-1:0]  f_clean, f_err;
  logic [FL-1:0]    d;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  viterbi_decoder #(.FRAME_LEN(FL), .METRIC_W(MW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
    .out_valid(out_valid), .out_bits(out_bits), .out_metric(out_metric)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [2*FL-1:0] enc(input logic [FL-1:0] data);
    logic s1, s0, u;
    logic [2*FL-1:0] r;
    s1 = 0; s0 = 0; r = '0;
    for (int i = 0; i < FL; i++) begin
      u = data[FL-1-i];
      r[2*FL-1-2*i -: 2] = {u ^ s1 ^ s0, u ^ s0};
      s0 = s1;
      s1 = u;
    end
    return r;
  endfunction
  task automatic send_sym(input logic [1:0] s, input bit stall);
    int w = 0;
    bit done = 0;
    if (stall) repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      in_valid = 0;
      in_sym = 2'($urandom);
    end
    while (!done) begin
      @(negedge clk);
      in_valid = 1;
      in_sym = s;
      if (in_ready) done = 1;
      else if (++w >= 50) begin
        chk("handshake_timeout", 0, 1);
        done = 1;
      end
    end
    last_hs = cyc + 1;
    last_wait = w;
  endtask
  task automatic send_frame(input logic [2*FL-1:0] syms, input bit stall, input bit push,
                            input logic [FL-1:0] eb, input logic [MW-1:0] em, input int n);
    for (int i = 0; i < n; i++) begin
      send_sym(syms[2*FL-1-2*i -: 2], stall);
      if (i == 0) first_wait = last_wait;
    end
    if (push) sb.push_back({eb, em});
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 0;
    end
  endtask
  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      in_valid = 0;
      k++;
    end
    chk("drain", sb.size(), 0);
  endtask
  always @(negedge clk) begin
    logic [FL+MW-1:0] e;
    if (out_valid) begin
      if (sb.size() == 0) chk("spurious_out_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out_bits", out_bits, e[FL+MW-1:MW]);
        chk("out_metric", out_metric, e[MW-1:0]);
        chk("latency", cyc - last_hs, FL + 1);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
  initial begin
    f_clean = enc(6'b011100);
    f_err = f_clean;
    f_err[7:6] = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bits", out_bits, 0);
    chk("rst_out_metric", out_metric, 0);
    send_frame(f_clean, 0, 1, 6'b011100, 0, FL); idle(10);
    send_frame(f_err, 0, 1, 6'b011100, 1, FL); idle(10);
    send_frame('0, 0, 1, 6'b000000, 0, FL); idle(10);
    send_frame(f_clean, 0, 1, 6'b011100, 0, FL);
    send_frame(enc(6'b110100), 0, 1, 6'b110100, 0, FL);
    chk("b2b_busy_cycles", first_wait, 8);
    idle(10);
    send_frame(f_clean, 1, 1, 6'b011100, 0, FL);
    send_frame(f_err, 1, 1, 6'b011100, 1, FL);
    send_frame('0, 1, 1, 6'b000000, 0, FL);
    repeat (4) begin
      d = FL'($urandom);
      send_frame(enc(d), 1, 1, d, 0, FL);
    end
    drain();
    send_frame(f_clean, 0, 0, '0, '0, 3);
    @(negedge clk); in_valid = 0; rst_n = 0;
    @(negedge clk); rst_n = 1;
    chk("rst_mid_in_ready", in_ready, 1);
    send_frame(f_clean, 0, 1, 6'b011100, 0, FL);
    drain();
    send_frame(enc(6'b110100), 0, 0, '0, '0, FL);
    @(negedge clk); in_valid = 0;
    @(negedge clk);
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    chk("rst_tb_in_ready", in_ready, 1);
    chk("rst_tb_out_valid", out_valid, 0);
    chk("rst_tb_out_bits", out_bits, 0);
    idle(15);
    send_frame(enc(6'b101101), 1, 1, 6'b101101, 0, FL);
    drain();
    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
